// File: rtl/app_spi_seq_if.sv
// OPB-style register bus bundle between a host and app_spi_seq.
// Latency: none (wires only); read data returns one cycle after APP_RE.
// Backpressure: none; strobes are single-cycle and always accepted.
//
// Signals: OPB_DI write data, OPB_DO registered read data, OPB_ADDR (bits [3:2]
// decoded), APP_RE / APP_WE single-cycle read / write strobes.
interface app_spi_seq_if;
   logic [31:0] OPB_DI;
   logic [31:0] OPB_DO;
   logic [31:0] OPB_ADDR;
   logic        APP_RE;
   logic        APP_WE;

   modport master (output OPB_DI, OPB_ADDR, APP_RE, APP_WE, input OPB_DO);
   modport slave  (input OPB_DI, OPB_ADDR, APP_RE, APP_WE, output OPB_DO);
endinterface

// File: rtl/app_spi_seq.sv
// Register-driven SPI mode-0 master (MSB first) with two chip selects and 1..32 bit transfers.
// Latency: read data one cycle after APP_RE; a transfer takes CLK_DIV*(2*LEN+4) cycles of CS_N low.
// Backpressure: none; START and TXDATA writes while BUSY are silently dropped.
//
// Ports: OPB_CLK, OPB_RST_N (async assert, sync deassert internally), opb (register bus,
// slave modport), APP_FPGA_SPI_CLK / SPIx_MOSI / SPIx_CS_N (registered pins), SPIx_MISO.
// Optional feature: define APP_SPI_SEQ_IRQ_EN to add the SPI_IRQ output (mirrors DONE).
// Registers (OPB_ADDR[3:2]): 0 CTRL (W: bit0 START, bit1 SEL, [12:8] LEN), 1 TXDATA (R/W),
// 2 RXDATA (R), 3 STATUS (R: {DONE, BUSY}, read clears DONE).
module app_spi_seq #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic         OPB_CLK,
   input  logic         OPB_RST_N,
   app_spi_seq_if.slave opb,
   output logic         APP_FPGA_SPI_CLK,
   output logic         APP_FPGA_SPI0_MOSI,
   output logic         APP_FPGA_SPI1_MOSI,
   output logic         APP_FPGA_SPI0_CS_N,
   output logic         APP_FPGA_SPI1_CS_N,
   input  logic         APP_FPGA_SPI0_MISO,
   input  logic         APP_FPGA_SPI1_MISO
`ifdef APP_SPI_SEQ_IRQ_EN
   ,
   output logic         SPI_IRQ
`endif
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SCK_HI,
      S_SCK_LO,
      S_HOLD
   } state_t;

   // Reset: assertion reaches every flop immediately, release waits two clocks.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) r_rst_sync <= 2'b00;
      else            r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   state_t      r_state;
   logic [7:0]  r_div;
   logic        r_busy;
   logic        r_done;
   logic        r_sel;
   logic        r_last;
   logic [4:0]  r_bit;
   logic [31:0] r_tx_sh;
   logic [31:0] r_rx_sh;
   logic [31:0] r_txdata;
   logic [31:0] r_rxdata;
   logic [31:0] r_do;
   logic        r_sclk;
   logic        r_cs0_n;
   logic        r_cs1_n;
   logic        r_mosi0;
   logic        r_mosi1;

   // Bus decode; a read always wins over a simultaneous write.
   logic [1:0]  w_addr;
   logic        w_wr;
   logic        w_start;
   logic        w_tx_wr;
   logic        w_stat_rd;
   logic        w_div_last;
   logic        w_hold_done;
   logic        w_miso;
   logic [4:0]  w_len;
   logic        w_sel_new;
   logic        w_first_bit;
   logic [31:0] w_rd_dat;
   logic        w_unused;

   assign w_addr      = opb.OPB_ADDR[3:2];
   assign w_wr        = opb.APP_WE & ~opb.APP_RE;
   assign w_start     = w_wr && (w_addr == 2'd0) && opb.OPB_DI[0] && (r_state == S_IDLE);
   assign w_tx_wr     = w_wr && (w_addr == 2'd1) && !r_busy;
   assign w_stat_rd   = opb.APP_RE && (w_addr == 2'd3);
   assign w_div_last  = (r_div == DIV_LAST);
   assign w_hold_done = (r_state == S_HOLD) && w_div_last;
   assign w_miso      = r_sel ? APP_FPGA_SPI1_MISO : APP_FPGA_SPI0_MISO;
   assign w_len       = opb.OPB_DI[12:8];
   assign w_sel_new   = opb.OPB_DI[1];
   assign w_first_bit = r_txdata[w_len];
   assign w_unused    = ^{opb.OPB_ADDR[31:4], opb.OPB_ADDR[1:0],
                          opb.OPB_DI[31:13], opb.OPB_DI[7:2]};

   always_comb begin
      w_rd_dat = '0;
      case (w_addr)
         2'd1:    w_rd_dat = r_txdata;
         2'd2:    w_rd_dat = r_rxdata;
         2'd3:    w_rd_dat = {30'b0, r_done, r_busy};
         default: w_rd_dat = '0;
      endcase
   end

   // Register file: TXDATA, DONE and the registered read port.
   always_ff @(posedge OPB_CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_txdata <= '0;
         r_done   <= 1'b0;
         r_do     <= '0;
      end else begin
         if (w_tx_wr) r_txdata <= opb.OPB_DI;
         // Setting DONE beats a same-cycle clear.
         if (w_hold_done)                r_done <= 1'b1;
         else if (w_start || w_stat_rd)  r_done <= 1'b0;
         r_do <= opb.APP_RE ? w_rd_dat : 32'd0;
      end
   end

`ifdef APP_SPI_SEQ_IRQ_EN
   logic r_irq;
   always_ff @(posedge OPB_CLK or negedge w_rst_n) begin
      if (!w_rst_n)                   r_irq <= 1'b0;
      else if (w_hold_done)           r_irq <= 1'b1;
      else if (w_start || w_stat_rd)  r_irq <= 1'b0;
   end
   assign SPI_IRQ = r_irq;
`endif

   // Transfer sequencer. The TX word is pre-shifted so the first bit sits at
   // bit 31; zeros shift in behind it, so MOSI returns to 0 after the last bit.
   always_ff @(posedge OPB_CLK or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state  <= S_IDLE;
         r_div    <= 8'd0;
         r_busy   <= 1'b0;
         r_sel    <= 1'b0;
         r_last   <= 1'b0;
         r_bit    <= 5'd0;
         r_tx_sh  <= '0;
         r_rx_sh  <= '0;
         r_rxdata <= '0;
         r_sclk   <= 1'b0;
         r_cs0_n  <= 1'b1;
         r_cs1_n  <= 1'b1;
         r_mosi0  <= 1'b0;
         r_mosi1  <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_div <= 8'd0;
         if (w_start) begin
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
            r_sel   <= w_sel_new;
            r_bit   <= w_len;
            r_tx_sh <= r_txdata << (5'd31 - w_len);
            r_rx_sh <= '0;
            r_cs0_n <= w_sel_new;
            r_cs1_n <= ~w_sel_new;
            r_mosi0 <= ~w_sel_new & w_first_bit;
            r_mosi1 <= w_sel_new & w_first_bit;
         end
      end else if (!w_div_last) begin
         r_div <= r_div + 8'd1;
      end else begin
         r_div <= 8'd0;
         case (r_state)
            S_SETUP, S_SCK_LO: begin
               if (r_state == S_SCK_LO && r_last) begin
                  r_state <= S_HOLD;
               end else begin
                  r_state <= S_SCK_HI;
                  r_sclk  <= 1'b1;
                  r_rx_sh <= {r_rx_sh[30:0], w_miso};
               end
            end
            S_SCK_HI: begin
               r_state <= S_SCK_LO;
               r_sclk  <= 1'b0;
               r_last  <= (r_bit == 5'd0);
               r_bit   <= r_bit - 5'd1;
               r_tx_sh <= {r_tx_sh[30:0], 1'b0};
               r_mosi0 <= ~r_sel & r_tx_sh[30];
               r_mosi1 <= r_sel & r_tx_sh[30];
            end
            S_HOLD: begin
               r_state  <= S_IDLE;
               r_busy   <= 1'b0;
               r_rxdata <= r_rx_sh;
               r_cs0_n  <= 1'b1;
               r_cs1_n  <= 1'b1;
               r_mosi0  <= 1'b0;
               r_mosi1  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign opb.OPB_DO         = r_do;
   assign APP_FPGA_SPI_CLK   = r_sclk;
   assign APP_FPGA_SPI0_CS_N = r_cs0_n;
   assign APP_FPGA_SPI1_CS_N = r_cs1_n;
   assign APP_FPGA_SPI0_MOSI = r_mosi0;
   assign APP_FPGA_SPI1_MOSI = r_mosi1;

endmodule
